xilinx_bram_rd_stream: RTL and testbench

Read-port front end for `xilinx_tdp_bram`. Accepts read addresses on a valid/ready request channel and drives one BRAM port's `EN`/`REGCE`/`ADDR`. It tracks the fixed BRAM read latency (1 or 2 cycles, set by the `DO*_REG` setting) and captures the returned `DO` data into a small credit-guarded buffer. That data is presented downstream as a valid/ready stream, so consumer backpressure never stalls or corrupts the BRAM pipeline.

---
 rtl/xilinx_bram_rd_stream_pkg.sv | 12 +
 rtl/xilinx_bram_rd_stream_if.sv | 33 +++
 rtl/xilinx_bram_rd_buf.sv | 61 ++++++
 rtl/xilinx_bram_rd_stream.sv | 78 +++++++
 tb/tb_xilinx_bram_rd_stream.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xilinx_bram_rd_stream_pkg.sv
// rtl/xilinx_bram_rd_stream_pkg.sv - shared constants and helpers for the BRAM read-stream front end
// Contents: BRAM_ADDR_W (native BRAM address width), bram_rd_latency(doreg) (read latency for a DO*_REG setting)
package xilinx_bram_rd_stream_pkg;

    localparam int BRAM_ADDR_W = 15;

    // DO*_REG=1 adds the optional output register stage to the read path.
    function automatic int bram_rd_latency(input int doreg);
        return 1 + doreg;
    endfunction

endpackage

// File: rtl/xilinx_bram_rd_stream_if.sv
// rtl/xilinx_bram_rd_stream_if.sv - request, BRAM port and read-data stream bundle
// Signals: REQ_* request channel, BRAM_* port drive/return, RD_* output stream, LEVEL credit usage
// Modports: slave = the front end itself, master = requester/consumer/BRAM side
interface xilinx_bram_rd_stream_if #(
    parameter int DATA_WIDTH   = 36,
    parameter int ADDR_WIDTH   = 15,
    parameter int READ_LATENCY = 1
);
    localparam int LEVEL_W = $clog2(READ_LATENCY + 2 + 1);

    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic [ADDR_WIDTH-1:0] REQ_ADDR;
    logic                  BRAM_EN;
    logic                  BRAM_REGCE;
    logic [ADDR_WIDTH-1:0] BRAM_ADDR;
    logic [DATA_WIDTH-1:0] BRAM_DO;
    logic                  RD_VALID;
    logic                  RD_READY;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic [LEVEL_W-1:0]    LEVEL;

    modport slave (
        input  REQ_VALID, REQ_ADDR, BRAM_DO, RD_READY,
        output REQ_READY, BRAM_EN, BRAM_REGCE, BRAM_ADDR, RD_VALID, RD_DATA, LEVEL
    );

    modport master (
        output REQ_VALID, REQ_ADDR, BRAM_DO, RD_READY,
        input  REQ_READY, BRAM_EN, BRAM_REGCE, BRAM_ADDR, RD_VALID, RD_DATA, LEVEL
    );

endinterface

// File: rtl/xilinx_bram_rd_buf.sv
// rtl/xilinx_bram_rd_buf.sv - circular FIFO capturing BRAM read data for the output stream
// Ports: clk_i, rst_n_i (async active-low), wr_en_i/wr_data_i (capture), rd_ready_i/rd_valid_o/rd_data_o (stream), count_o (occupancy)
module xilinx_bram_rd_buf #(
    parameter int DATA_WIDTH = 36,
    parameter int DEPTH      = 3,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_ready_i,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [CNT_W-1:0]      count_o
);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pop;

    // DEPTH is usually not a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign pop        = rd_ready_i & (count_q != '0);
    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_comb begin
        wr_ptr_d = wr_en_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_en_i) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; count gates its visibility.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/xilinx_bram_rd_stream.sv
// rtl/xilinx_bram_rd_stream.sv - BRAM read-port front end with latency tracking and credit-guarded output buffer
// Ports: CLK, RST_N (async active-low), bus (slave): REQ_* request channel, BRAM_* port drive/return, RD_* stream, LEVEL
module xilinx_bram_rd_stream
    import xilinx_bram_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 36,
    parameter int ADDR_WIDTH   = BRAM_ADDR_W,
    parameter int READ_LATENCY = bram_rd_latency(0)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    xilinx_bram_rd_stream_if.slave bus
);
    localparam int BUF_DEPTH = READ_LATENCY + 2;
    localparam int LEVEL_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [LEVEL_W-1:0] CREDITS = LEVEL_W'(BUF_DEPTH);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("xilinx_bram_rd_stream: READ_LATENCY must be 1 or 2");
    end

    logic [READ_LATENCY-1:0] vpipe_q, vpipe_d;
    logic [LEVEL_W-1:0]      inflight_q, inflight_d;
    logic [LEVEL_W-1:0]      count;
    logic [LEVEL_W-1:0]      level;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    req_ready;
    logic                    acc;
    logic                    capture;

    // Credits cover both in-flight reads and buffered beats, so every
    // accepted read has a guaranteed slot when its data returns.
    // RD_READY is intentionally absent here: a freed credit shows up one
    // cycle later through count.
    assign level     = inflight_q + count;
    assign req_ready = RST_N & (level < CREDITS);
    assign acc       = bus.REQ_VALID & req_ready;
    assign capture   = vpipe_q[READ_LATENCY-1];
    assign addr      = bus.REQ_ADDR;

    assign bus.REQ_READY  = req_ready;
    assign bus.BRAM_EN    = acc;
    assign bus.BRAM_ADDR  = addr;
    // The output register stage is clocked one cycle after the array read.
    assign bus.BRAM_REGCE = (READ_LATENCY == 2) ? vpipe_q[0] : 1'b0;
    assign bus.LEVEL      = level;

    always_comb begin
        vpipe_d    = vpipe_q << 1;
        vpipe_d[0] = acc;
        inflight_d = inflight_q + LEVEL_W'(acc) - LEVEL_W'(capture);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vpipe_q    <= '0;
            inflight_q <= '0;
        end else begin
            vpipe_q    <= vpipe_d;
            inflight_q <= inflight_d;
        end
    end

    xilinx_bram_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk_i      (CLK),
        .rst_n_i    (RST_N),
        .wr_en_i    (capture),
        .wr_data_i  (bus.BRAM_DO),
        .rd_ready_i (bus.RD_READY),
        .rd_valid_o (bus.RD_VALID),
        .rd_data_o  (bus.RD_DATA),
        .count_o    (count)
    );

endmodule

// File: tb/tb_xilinx_bram_rd_stream.sv
// tb/tb_xilinx_bram_rd_stream.sv - self-checking bench for xilinx_bram_rd_stream at read latency 1 and 2
module tb_xilinx_bram_rd_stream;
    import xilinx_bram_rd_stream_pkg::*;

    localparam int DW = 36;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    xilinx_bram_rd_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) bus1 ();
    xilinx_bram_rd_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) bus2 ();

    xilinx_bram_rd_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut1 (
        .CLK (clk), .RST_N (rst_n), .bus (bus1)
    );
    xilinx_bram_rd_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(bram_rd_latency(1))) u_dut2 (
        .CLK (clk), .RST_N (rst_n), .bus (bus2)
    );

    // BRAM contents: address 0x10 holds 0xA5, everything else is address-derived.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        if (a == 15'h10) return 36'hA5;
        return {6'h2A, a, ~a};
    endfunction

    // BRAM port models: array read on EN, optional output register on REGCE.
    logic [DW-1:0] q1, q2, r2;
    always @(posedge clk) if (bus1.BRAM_EN) q1 <= mem_f(bus1.BRAM_ADDR);
    always @(posedge clk) begin
        if (bus2.BRAM_EN)    q2 <= mem_f(bus2.BRAM_ADDR);
        if (bus2.BRAM_REGCE) r2 <= q2;
    end
    assign bus1.BRAM_DO = q1;
    assign bus2.BRAM_DO = r2;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic          r;
        logic          e_ready;
        logic          e_en;
        logic          e_regce;
        logic          e_valid;
        int            e_level;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t tbl[13];

    int issued, got, ready_drop, regce_bad, data_bad, first_c, last_c;
    int sent, recv, bad, lvl_bad, extra;
    logic prev_en;
    logic [AW-1:0] sb[$];

    initial begin
        // Backpressure on latency 2 (4 credits): v, a, r | ready, en, regce, valid, level, head addr
        tbl[0]  = '{1'b1, 15'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 15'h00};
        tbl[1]  = '{1'b1, 15'h21, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 15'h00};
        tbl[2]  = '{1'b1, 15'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 15'h00};
        tbl[3]  = '{1'b1, 15'h23, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 15'h20};
        tbl[4]  = '{1'b1, 15'h24, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 15'h20};
        tbl[5]  = '{1'b1, 15'h24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 15'h20};
        tbl[6]  = '{1'b1, 15'h24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 15'h20};
        tbl[7]  = '{1'b1, 15'h24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 15'h20};
        tbl[8]  = '{1'b1, 15'h24, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3, 15'h21};
        tbl[9]  = '{1'b0, 15'h25, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3, 15'h22};
        tbl[10] = '{1'b0, 15'h25, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 15'h23};
        tbl[11] = '{1'b0, 15'h25, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 15'h24};
        tbl[12] = '{1'b0, 15'h25, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 15'h00};

        // Reset state, with requests offered to show they are refused.
        rst_n = 1'b0;
        bus1.REQ_VALID = 1'b1; bus1.REQ_ADDR = '0; bus1.RD_READY = 1'b0;
        bus2.REQ_VALID = 1'b1; bus2.REQ_ADDR = '0; bus2.RD_READY = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.l1.req_ready", bus1.REQ_READY, 0);
        chk("rst.l1.bram_en",   bus1.BRAM_EN, 0);
        chk("rst.l1.rd_valid",  bus1.RD_VALID, 0);
        chk("rst.l1.level",     bus1.LEVEL, 0);
        chk("rst.l2.req_ready", bus2.REQ_READY, 0);
        chk("rst.l2.bram_en",   bus2.BRAM_EN, 0);
        chk("rst.l2.regce",     bus2.BRAM_REGCE, 0);
        chk("rst.l2.rd_valid",  bus2.RD_VALID, 0);
        chk("rst.l2.level",     bus2.LEVEL, 0);

        @(negedge clk);
        bus1.REQ_VALID = 1'b0; bus2.REQ_VALID = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel.l1.req_ready", bus1.REQ_READY, 1);
        chk("rel.l2.req_ready", bus2.REQ_READY, 1);

        // Latency 1: single read of 0x10.
        @(negedge clk);
        bus1.REQ_VALID = 1'b1; bus1.REQ_ADDR = 15'h10; bus1.RD_READY = 1'b1;
        #1;
        chk("l1.c0.req_ready", bus1.REQ_READY, 1);
        chk("l1.c0.bram_en",   bus1.BRAM_EN, 1);
        chk("l1.c0.bram_addr", bus1.BRAM_ADDR, 15'h10);
        chk("l1.c0.rd_valid",  bus1.RD_VALID, 0);
        @(negedge clk);
        bus1.REQ_VALID = 1'b0;
        #1;
        chk("l1.c1.bram_en",  bus1.BRAM_EN, 0);
        chk("l1.c1.regce",    bus1.BRAM_REGCE, 0);
        chk("l1.c1.rd_valid", bus1.RD_VALID, 0);
        chk("l1.c1.level",    bus1.LEVEL, 1);
        @(negedge clk);
        #1;
        chk("l1.c2.rd_valid", bus1.RD_VALID, 1);
        chk("l1.c2.rd_data",  bus1.RD_DATA, 36'hA5);
        @(negedge clk);
        #1;
        chk("l1.c3.rd_valid", bus1.RD_VALID, 0);
        chk("l1.c3.level",    bus1.LEVEL, 0);
        bus1.RD_READY = 1'b0;

        // Latency 2: backpressure table.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus2.REQ_VALID = tbl[i].v; bus2.REQ_ADDR = tbl[i].a; bus2.RD_READY = tbl[i].r;
            #1;
            chk($sformatf("bp[%0d].req_ready", i), bus2.REQ_READY, tbl[i].e_ready);
            chk($sformatf("bp[%0d].bram_en", i),   bus2.BRAM_EN, tbl[i].e_en);
            chk($sformatf("bp[%0d].regce", i),     bus2.BRAM_REGCE, tbl[i].e_regce);
            chk($sformatf("bp[%0d].rd_valid", i),  bus2.RD_VALID, tbl[i].e_valid);
            chk($sformatf("bp[%0d].level", i),     bus2.LEVEL, 64'(tbl[i].e_level));
            if (tbl[i].e_valid) chk($sformatf("bp[%0d].rd_data", i), bus2.RD_DATA, mem_f(tbl[i].e_addr));
        end

        // Latency 2: 100 back-to-back reads of addresses 0..99.
        issued = 0; got = 0; ready_drop = 0; regce_bad = 0; data_bad = 0;
        first_c = -1; last_c = -1; prev_en = 1'b0;
        for (int c = 0; c < 140 && got < 100; c++) begin
            @(negedge clk);
            bus2.REQ_VALID = (issued < 100); bus2.REQ_ADDR = 15'(issued); bus2.RD_READY = 1'b1;
            #1;
            if (bus2.REQ_VALID && !bus2.REQ_READY) ready_drop++;
            if (bus2.BRAM_REGCE !== prev_en) regce_bad++;
            prev_en = bus2.BRAM_EN;
            if (bus2.RD_VALID) begin
                if (bus2.RD_DATA !== mem_f(15'(got))) data_bad++;
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            if (bus2.REQ_VALID && bus2.REQ_READY) issued++;
        end
        chk("b2b.beats",       64'(got), 100);
        chk("b2b.ready_drops", 64'(ready_drop), 0);
        chk("b2b.regce_errs",  64'(regce_bad), 0);
        chk("b2b.data_errs",   64'(data_bad), 0);
        chk("b2b.first_cycle", 64'(first_c), 3);
        chk("b2b.span",        64'(last_c - first_c), 99);
        @(negedge clk);
        bus2.REQ_VALID = 1'b0;
        repeat (4) @(negedge clk);

        // Latency 2: random traffic against the scoreboard.
        sent = 0; recv = 0; bad = 0; lvl_bad = 0;
        for (int c = 0; c < 60000 && recv < 10000; c++) begin
            @(negedge clk);
            bus2.REQ_VALID = (sent < 10000) && ($urandom_range(0, 1) == 1);
            bus2.REQ_ADDR  = 15'($urandom);
            bus2.RD_READY  = ($urandom_range(0, 1) == 1);
            #1;
            if (bus2.LEVEL > 3'd4) lvl_bad++;
            if (bus2.REQ_VALID && bus2.REQ_READY) begin
                sb.push_back(bus2.REQ_ADDR);
                sent++;
            end
            if (bus2.RD_VALID && bus2.RD_READY) begin
                if (sb.size() == 0) bad++;
                else if (bus2.RD_DATA !== mem_f(sb.pop_front())) bad++;
                recv++;
            end
        end
        @(negedge clk);
        bus2.REQ_VALID = 1'b0; bus2.RD_READY = 1'b1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus2.RD_VALID) extra++;
            @(negedge clk);
        end
        #1;
        chk("rand.beats",      64'(recv), 10000);
        chk("rand.data_errs",  64'(bad), 0);
        chk("rand.level_over", 64'(lvl_bad), 0);
        chk("rand.extra",      64'(extra), 0);
        chk("rand.sb_left",    64'(sb.size()), 0);
        chk("rand.end_level",  bus2.LEVEL, 0);

        // Latency 2: reset with two reads in flight and one buffered.
        @(negedge clk);
        bus2.RD_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus2.REQ_VALID = 1'b1; bus2.REQ_ADDR = 15'(16'h30 + k);
        end
        @(negedge clk);
        bus2.REQ_ADDR = 15'h33;
        #1;
        chk("mid.pre.level",    bus2.LEVEL, 3);
        chk("mid.pre.rd_valid", bus2.RD_VALID, 1);
        rst_n = 1'b0;
        #1;
        chk("mid.rst.rd_valid",  bus2.RD_VALID, 0);
        chk("mid.rst.level",     bus2.LEVEL, 0);
        chk("mid.rst.bram_en",   bus2.BRAM_EN, 0);
        chk("mid.rst.req_ready", bus2.REQ_READY, 0);
        repeat (2) @(negedge clk);
        bus2.REQ_VALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus2.REQ_VALID = 1'b1; bus2.REQ_ADDR = 15'h55; bus2.RD_READY = 1'b1;
        #1;
        chk("post.c0.req_ready", bus2.REQ_READY, 1);
        chk("post.c0.bram_en",   bus2.BRAM_EN, 1);
        @(negedge clk);
        bus2.REQ_VALID = 1'b0;
        #1;
        chk("post.c1.rd_valid", bus2.RD_VALID, 0);
        @(negedge clk);
        #1;
        chk("post.c2.rd_valid", bus2.RD_VALID, 0);
        @(negedge clk);
        #1;
        chk("post.c3.rd_valid", bus2.RD_VALID, 1);
        chk("post.c3.rd_data",  bus2.RD_DATA, mem_f(15'h55));
        @(negedge clk);
        #1;
        chk("post.c4.rd_valid", bus2.RD_VALID, 0);
        chk("post.c4.level",    bus2.LEVEL, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
